// File: rtl/mac_drain.sv
// mac_drain: snapshots a row of PE accumulators on start, clears the PEs,
// then streams rounded/saturated words one per cycle over valid/ready.
module mac_drain #(
    parameter int N     = 4,
    parameter int ACC_W = 33,
    parameter int OUT_W = 16,
    parameter int SHIFT = 4,
    localparam int IW   = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N*ACC_W-1:0] acc_flat,
    output logic               pe_clear,
    output logic               busy,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [OUT_W-1:0]   out_data,
    output logic [IW-1:0]      out_idx,
    output logic               out_last,
    output logic               out_sat,
    output logic [IW:0]        sat_count
);

    typedef enum logic {IDLE, STREAM} state_t;

    // Rounding constant 2^(SHIFT-1), or 0 when no shift is applied.
    localparam logic signed [ACC_W:0] HALF =
        (ACC_W+1)'((64'd1 << SHIFT) >> 1);
    localparam logic signed [ACC_W:0] MAXV =
        (ACC_W+1)'((64'sd1 <<< (OUT_W-1)) - 64'sd1);
    localparam logic signed [ACC_W:0] MINV = ~MAXV;

    state_t            state;
    state_t            state_nxt;
    logic [ACC_W-1:0]  snap [N];
    logic [IW-1:0]     idx;
    logic [IW:0]       cnt;
    logic              stream;
    logic              fire;
    logic              last;
    logic              sat_w;
    logic [OUT_W-1:0]  word;
    logic signed [ACC_W:0] xe;
    logic signed [ACC_W:0] r;

    assign stream = (state == STREAM);
    assign last   = (idx == IW'(N - 1));
    assign fire   = stream & out_ready;

    // Round-to-nearest (ties up) and saturate the entry at the current index.
    always_comb begin
        xe    = {snap[idx][ACC_W-1], snap[idx]};
        r     = (xe + HALF) >>> SHIFT;
        word  = r[OUT_W-1:0];
        sat_w = 1'b0;
        if (r > MAXV) begin
            word  = MAXV[OUT_W-1:0];
            sat_w = 1'b1;
        end else if (r < MINV) begin
            word  = MINV[OUT_W-1:0];
            sat_w = 1'b1;
        end
    end

    // Next-state logic: capture on start in IDLE, return after last transfer.
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (start) state_nxt = STREAM;
            STREAM:  if (fire && last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Snapshot bank, word index and saturation counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx <= '0;
            cnt <= '0;
            for (int k = 0; k < N; k++) snap[k] <= '0;
        end else if (state == IDLE && start) begin
            idx <= '0;
            cnt <= '0;
            for (int k = 0; k < N; k++)
                snap[k] <= acc_flat[k*ACC_W +: ACC_W];
        end else if (fire) begin
            idx <= last ? '0 : idx + 1'b1;
            if (sat_w) cnt <= cnt + 1'b1;
        end
    end

    assign pe_clear  = start & (state == IDLE) & ~rst;
    assign busy      = stream;
    assign out_valid = stream;
    assign out_data  = stream ? word : '0;
    assign out_idx   = stream ? idx : '0;
    assign out_last  = stream & last;
    assign out_sat   = stream & sat_w;
    assign sat_count = cnt;

endmodule

// File: tb/tb_mac_drain.sv
// tb_mac_drain: directed scenario tests for mac_drain with N=4,
// ACC_W=33, OUT_W=16, SHIFT=4; inputs driven and outputs sampled at negedge.
module tb_mac_drain;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [131:0] acc_flat;
    logic         pe_clear;
    logic         busy;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  out_data;
    logic [1:0]   out_idx;
    logic         out_last;
    logic         out_sat;
    logic [2:0]   sat_count;

    int n_chk  = 0;
    int n_fail = 0;

    mac_drain #(.N(4), .ACC_W(33), .OUT_W(16), .SHIFT(4)) dut (
        .clk(clk), .rst(rst), .start(start), .acc_flat(acc_flat),
        .pe_clear(pe_clear), .busy(busy), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_idx(out_idx),
        .out_last(out_last), .out_sat(out_sat), .sat_count(sat_count)
    );

    always #5 clk = ~clk;

    task automatic set_acc(input longint a0, input longint a1,
                           input longint a2, input longint a3);
        acc_flat = {33'(a3), 33'(a2), 33'(a1), 33'(a0)};
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; out_ready = 1'b1;
        set_acc(291, -24, 8, -8);
        @(negedge clk); @(negedge clk);
        #1;
        n_chk++;
        if (pe_clear !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_pe_clear got=%b exp=0", pe_clear);
        end
        n_chk++;
        if ({busy, out_valid, out_last, out_sat, out_data, out_idx, sat_count}
            !== 25'd0) begin
            n_fail++;
            $display("FAIL reset_outputs got=%b%b%b%b %h %h %h exp=all zero",
                     busy, out_valid, out_last, out_sat, out_data, out_idx,
                     sat_count);
        end
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_snapshot busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_basic;
        int ed[4] = '{18, -1, 1, 0};
        set_acc(291, -24, 8, -8);
        out_ready = 1'b1; start = 1'b1;
        #1;
        n_chk++;
        if ({pe_clear, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL basic_pe_clear got=%b%b exp=10", pe_clear, busy);
        end
        @(negedge clk); start = 1'b0;
        #1;
        n_chk++;
        if (pe_clear !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_pe_clear_width got=%b exp=0", pe_clear);
        end
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if ({busy, out_valid, out_idx, out_last, out_sat, out_data} !==
                {1'b1, 1'b1, 2'(i), (i == 3), 1'b0, 16'(ed[i])}) begin
                n_fail++;
                $display("FAIL basic_word%0d got idx=%0d last=%b sat=%b d=%0d exp d=%0d",
                         i, out_idx, out_last, out_sat, $signed(out_data), ed[i]);
            end
            @(negedge clk);
        end
        n_chk++;
        if ({busy, out_valid, sat_count} !== 5'd0) begin
            n_fail++;
            $display("FAIL basic_end got busy=%b valid=%b satc=%0d exp 0 0 0",
                     busy, out_valid, sat_count);
        end
    endtask

    task automatic test_saturation;
        int ed[4] = '{32767, -32768, 32767, 32767};
        bit es[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        set_acc(1048576, -(64'sd1 <<< 32), 524272, 64'h7FFF_FFFF);
        out_ready = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if ({out_valid, out_idx, out_sat, out_data} !==
                {1'b1, 2'(i), es[i], 16'(ed[i])}) begin
                n_fail++;
                $display("FAIL sat_word%0d got idx=%0d sat=%b d=%0d exp sat=%b d=%0d",
                         i, out_idx, out_sat, $signed(out_data), es[i], ed[i]);
            end
            @(negedge clk);
        end
        n_chk++;
        if ({busy, sat_count} !== {1'b0, 3'd3}) begin
            n_fail++;
            $display("FAIL sat_count got busy=%b satc=%0d exp 0 3", busy, sat_count);
        end
    endtask

    task automatic test_backpressure;
        int ed[4] = '{18, -1, 1, 0};
        bit pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        int k = 0;
        set_acc(291, -24, 8, -8);
        out_ready = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 7; i++) begin
            out_ready = pat[i];
            n_chk++;
            if ({out_valid, out_idx, out_last, out_data} !==
                {1'b1, 2'(k), (k == 3), 16'(ed[k])}) begin
                n_fail++;
                $display("FAIL bp_step%0d got v=%b idx=%0d d=%0d exp idx=%0d d=%0d",
                         i, out_valid, out_idx, $signed(out_data), k, ed[k]);
            end
            if (pat[i]) k++;
            @(negedge clk);
        end
        out_ready = 1'b1;
        n_chk++;
        if ({busy, out_valid} !== 2'b00) begin
            n_fail++;
            $display("FAIL bp_end got busy=%b valid=%b exp 0 0", busy, out_valid);
        end
    endtask

    task automatic test_ignored_start;
        int ea[4] = '{18, -1, 1, 0};
        int eb[4] = '{6, -6, 3, -2};
        set_acc(291, -24, 8, -8);
        out_ready = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin
                set_acc(1000, 1000, 1000, 1000);
                start = 1'b1;
                #1;
                n_chk++;
                if (pe_clear !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ign_pe_clear_stream got=%b exp=0", pe_clear);
                end
            end else if (i == 3) begin
                set_acc(100, -100, 40, -40);
                start = 1'b1;
                #1;
                n_chk++;
                if (pe_clear !== 1'b0) begin
                    n_fail++;
                    $display("FAIL ign_pe_clear_last got=%b exp=0", pe_clear);
                end
            end else begin
                start = 1'b0;
            end
            n_chk++;
            if ({out_idx, out_data} !== {2'(i), 16'(ea[i])}) begin
                n_fail++;
                $display("FAIL ign_word%0d got idx=%0d d=%0d exp d=%0d",
                         i, out_idx, $signed(out_data), ea[i]);
            end
            @(negedge clk);
        end
        #1;
        n_chk++;
        if ({busy, pe_clear} !== 2'b01) begin
            n_fail++;
            $display("FAIL ovl_restart got busy=%b clr=%b exp 0 1", busy, pe_clear);
        end
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if ({out_valid, out_idx, out_data} !== {1'b1, 2'(i), 16'(eb[i])}) begin
                n_fail++;
                $display("FAIL ovl_word%0d got idx=%0d d=%0d exp d=%0d",
                         i, out_idx, $signed(out_data), eb[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_isolation;
        int eb[4] = '{6, -6, 3, -2};
        set_acc(100, -100, 40, -40);
        out_ready = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        acc_flat = '1;
        for (int i = 0; i < 4; i++) begin
            n_chk++;
            if ({out_idx, out_sat, out_data} !== {2'(i), 1'b0, 16'(eb[i])}) begin
                n_fail++;
                $display("FAIL iso_word%0d got idx=%0d d=%0d exp d=%0d",
                         i, out_idx, $signed(out_data), eb[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid;
        set_acc(291, -24, 8, -8);
        out_ready = 1'b1; start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk); @(negedge clk);
        n_chk++;
        if (out_idx !== 2'd2) begin
            n_fail++;
            $display("FAIL rstmid_pre idx got=%0d exp=2", out_idx);
        end
        rst = 1'b1;
        @(negedge clk);
        n_chk++;
        if ({busy, out_valid, out_last, out_sat, out_data, out_idx, sat_count}
            !== 25'd0) begin
            n_fail++;
            $display("FAIL rstmid_outputs got busy=%b v=%b d=%h idx=%0d exp zeros",
                     busy, out_valid, out_data, out_idx);
        end
        rst = 1'b0; start = 1'b1;
        #1;
        n_chk++;
        if (pe_clear !== 1'b1) begin
            n_fail++;
            $display("FAIL rstmid_restart_clr got=%b exp=1", pe_clear);
        end
        @(negedge clk); start = 1'b0;
        n_chk++;
        if ({out_valid, out_idx, out_data} !== {1'b1, 2'd0, 16'd18}) begin
            n_fail++;
            $display("FAIL rstmid_word0 got idx=%0d d=%0d exp idx=0 d=18",
                     out_idx, $signed(out_data));
        end
        repeat (4) @(negedge clk);
        n_chk++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_end busy got=%b exp=0", busy);
        end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; out_ready = 1'b0; acc_flat = '0;
        @(negedge clk);
        test_reset;
        test_basic;
        test_saturation;
        test_backpressure;
        test_ignored_start;
        test_isolation;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_drain.md
# mac_drain

Result-drain stage directly downstream of a row of `mac_pe` accumulators. On a `start` pulse it snapshots all N accumulator values (`c_out`) and clears the PEs in the same cycle. It then rounds, shifts and saturates each value to OUT_W bits and streams the words out one at a time over a valid/ready interface. This frees the array to begin the next accumulation while results drain.

## Interface

Parameters:
- `N`, 4, number of PE accumulators drained (≥ 2)
- `ACC_W`, 33, accumulator width (matches PE `ACC_W`)
- `OUT_W`, 16, output word width (< ACC_W)
- `SHIFT`, 4, arithmetic right shift applied before saturation (0 ≤ SHIFT < ACC_W - 1)

Ports:
- `clk`  in  1  single clock; all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  accumulation complete; request snapshot and drain
- `acc_flat`  in  N*ACC_W  PE `c_out` values, PE k at `[k*ACC_W +: ACC_W]`, signed
- `pe_clear`  out  1  combinational; drives `clear` of all PEs
- `busy`  out  1  high while a drain is in progress
- `out_valid`  out  1  output word valid
- `out_ready`  in  1  consumer accepts word
- `out_data`  out  OUT_W  rounded and saturated result, signed
- `out_idx`  out  clog2(N)  PE index of the current word
- `out_last`  out  1  current word is index N-1
- `out_sat`  out  1  current word was saturated
- `sat_count`  out  clog2(N)+1  number of saturated words in the current or most recent drain

## Operation

- FSM states: IDLE, STREAM.
- IDLE:
  - `start` is accepted when high in IDLE.
  - On the accepting edge, all N values of `acc_flat` are registered into the snapshot bank.
  - The word index is set to 0, `sat_count` is set to 0, and the FSM moves to STREAM.
- `pe_clear`:
  - Equals `start & (state==IDLE) & ~rst`.
  - PEs therefore clear on the same edge that the snapshot captures their pre-clear value. No accumulation is lost or doubled.
  - Upstream guarantees PE `en` is low in the `start` cycle. A product presented in that cycle is discarded by PE clear priority.
- STREAM:
  - `out_valid` is 1 and `busy` is 1.
  - `out_data`, `out_sat` and `out_idx` reflect the snapshot entry at the current index.
  - A transfer occurs when `out_valid & out_ready`. On transfer, the index increments. If `out_sat` is set, `sat_count` increments.
  - A transfer at index N-1 returns the FSM to IDLE.
- `start` in STREAM is ignored: no snapshot, no `pe_clear`.
- Arithmetic for each word, with x the signed ACC_W snapshot entry:
  - If SHIFT > 0: r = (x + 2^(SHIFT-1)) >>> SHIFT, computed at ACC_W+1 bits so the rounding add cannot overflow. This is round-to-nearest with ties toward +∞.
  - If SHIFT = 0: r = x.
  - If r > 2^(OUT_W-1) - 1: `out_data` = 2^(OUT_W-1) - 1 and `out_sat` = 1.
  - If r < -2^(OUT_W-1): `out_data` = -2^(OUT_W-1) and `out_sat` = 1.
  - Otherwise `out_data` = r[OUT_W-1:0] and `out_sat` = 0.
- Rounding and saturation may be combinational from the snapshot or precomputed at capture. Either way, output must be stable and valid in the first STREAM cycle.
- Reset values:
  - State is IDLE.
  - `busy`, `out_valid`, `out_last`, `out_sat` and `pe_clear` are 0.
  - `out_data`, `out_idx` and `sat_count` are 0.
  - The snapshot bank is zeroed.
- Reset mid-STREAM aborts the drain immediately. Remaining words are dropped, with no `pe_clear` on the reset cycle.

## Timing

- `start` high at edge T (in IDLE):
  - `pe_clear` is high during the cycle before T.
  - Snapshot is taken at T.
  - `out_valid` and `busy` are high from T+1.
- Latency from `start` to the first word valid is 1 cycle.
- Throughput is 1 word per cycle while `out_ready` is held high. A full drain takes N cycles.
- While `out_valid & ~out_ready`, `out_data`, `out_idx`, `out_last` and `out_sat` hold stable.
- `out_valid` never drops without a transfer, except on `rst`.
- `busy` falls on the cycle after the last transfer.
- The earliest next `start` is accepted in that cycle, which gives a minimum start-to-start spacing of N+1 cycles with `out_ready` high.
- `start` coincident with the last transfer is ignored.
- `rst` and `start` in the same cycle: reset wins, `pe_clear` is 0, and no snapshot is taken.

## Test plan

- **Basic drain:** N=4, SHIFT=4, OUT_W=16, acc = {291, -24, 8, -8}, `start`, `out_ready` = 1.
  - Required response: `pe_clear` high 1 cycle.
  - Words {18, -1, 1, 0} on idx 0..3 in 4 consecutive cycles.
  - `out_last` only on idx 3; `sat_count` = 0; `busy` low afterwards.
- **Saturation:** acc = {2^20, -2^32, 32767·16, 0x7FFF_FFFF}.
  - Required response: words {32767 sat, -32768 sat, 32767 no-sat, 32767 sat}.
  - `sat_count` = 3.
- **Backpressure:** `out_ready` toggles 1,0,0,1,0,1,1.
  - Required response: each word held unchanged while stalled.
  - Exactly 4 transfers in order; no duplicated or skipped idx.
- **Ignored start and overlap:**
  - Pulse `start` at STREAM idx 1 → no `pe_clear`, snapshot unchanged.
  - After the drain, change `acc_flat` and pulse `start` the cycle `busy` falls → new values drained.
- **Snapshot isolation:** after capture, drive `acc_flat` to all-ones during STREAM.
  - Required response: output still reflects the captured values.
- **Reset mid-drain:** assert `rst` at idx 2.
  - Required response: next cycle all outputs 0 and state IDLE.
  - A subsequent `start` drains correctly from idx 0.
